// File: rtl/rom_access_arbiter_pkg.sv
// Shared constants and types for the instruction-ROM read-port arbiter.
package rom_access_arbiter_pkg;

  localparam int   INST_ADDR_W  = 32;
  localparam int   INST_W       = 32;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ROM_OWN_NONE = 2'b00,
    ROM_OWN_IF   = 2'b01,
    ROM_OWN_DBG  = 2'b10
  } rom_owner_e;

  typedef struct packed {
    logic                   req;
    logic [INST_ADDR_W-1:0] addr;
  } rom_req_t;

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// Saturating starvation counter for a low-priority requester on a shared port.
module rom_arb_starve_ctr #(
  parameter int MAX_STARVE = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,        // low-priority requester pending
  input  logic lost,       // it lost arbitration this cycle
  input  logic won,        // it was granted (request consumed) this cycle
  output logic force_dbg
);
  import rom_access_arbiter_pkg::*;

  logic [CNT_W-1:0] cnt;

  assign force_dbg = (cnt == CNT_W'(MAX_STARVE));

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE)        cnt <= '0;
    else if (!req || won)         cnt <= '0;
    else if (lost && !force_dbg)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Arbitrates the instruction-ROM read port between IF (priority) and debug,
// with starvation relief for debug and a registered 1-cycle read response.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = 4,
  parameter int CNT_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [INST_ADDR_W-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [INST_W-1:0]      if_rdata,
  input  logic                   dbg_req,
  input  logic [INST_ADDR_W-1:0] dbg_addr,
  output logic                   dbg_gnt,
  output logic                   dbg_rvalid,
  output logic [INST_W-1:0]      dbg_rdata,
  output logic                   dbg_err,
  output logic                   rom_ce,
  output logic [INST_ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0]      rom_data,
  output logic                   stallreq
);

  rom_req_t   if_r, dbg_r;
  rom_owner_e owner, resp_sel;
  logic       force_dbg, dbg_mis, dbg_access;

  assign if_r  = '{req: if_req,  addr: if_addr};
  assign dbg_r = '{req: dbg_req, addr: dbg_addr};

  assign dbg_mis    = dbg_r.req && (dbg_r.addr[1:0] != 2'b00);
  // A misaligned debug read is consumed without touching the ROM, so IF may still use it.
  assign dbg_access = dbg_r.req && !dbg_mis && (!if_r.req || force_dbg);

  always_comb begin
    owner    = ROM_OWN_NONE;
    if_gnt   = 1'b0;
    dbg_gnt  = 1'b0;
    rom_ce   = CHIP_DISABLE;
    rom_addr = '0;
    stallreq = 1'b0;
    if (rst != RST_ENABLE) begin
      if (dbg_access)    owner = ROM_OWN_DBG;
      else if (if_r.req) owner = ROM_OWN_IF;
      dbg_gnt  = dbg_access || dbg_mis;
      if_gnt   = (owner == ROM_OWN_IF);
      stallreq = if_r.req && !if_gnt;
      case (owner)
        ROM_OWN_IF: begin
          rom_ce   = CHIP_ENABLE;
          rom_addr = if_r.addr;
        end
        ROM_OWN_DBG: begin
          rom_ce   = CHIP_ENABLE;
          rom_addr = dbg_r.addr;
        end
        default: ;
      endcase
    end
  end

  rom_arb_starve_ctr #(
    .MAX_STARVE (MAX_STARVE),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .req       (dbg_r.req),
    .lost      (dbg_r.req && !dbg_gnt),
    .won       (dbg_gnt),
    .force_dbg (force_dbg)
  );

  // Response stage: rvalid follows the registered owner; unselected rdata holds.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      resp_sel  <= ROM_OWN_NONE;
      dbg_err   <= 1'b0;
      if_rdata  <= ZERO_WORD;
      dbg_rdata <= ZERO_WORD;
    end else begin
      resp_sel <= owner;
      dbg_err  <= dbg_mis;
      if (owner == ROM_OWN_IF)  if_rdata  <= rom_data;
      if (owner == ROM_OWN_DBG) dbg_rdata <= rom_data;
    end
  end

  assign if_rvalid  = (resp_sel == ROM_OWN_IF);
  assign dbg_rvalid = (resp_sel == ROM_OWN_DBG);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench: driver checks grant-cycle outputs and queues expected responses;
// a monitor pops and compares whenever a response/error appears.
module tb_rom_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, dbg_err, rom_ce, stallreq;
  logic [31:0] if_rdata, dbg_rdata, rom_addr, rom_data;

  logic [31:0] mem [16];
  logic [31:0] if_q[$];
  logic [31:0] dbg_q[$];
  int          err_q[$];
  int          total = 0, bad = 0;
  logic        done = 1'b0;

  localparam logic [31:0] M0 = 32'hC0DE_0000, M1 = 32'hC0DE_0101, M2 = 32'hC0DE_0202,
                          M3 = 32'hC0DE_0303, M4 = 32'hC0DE_0404, M5 = 32'hC0DE_0505;

  always #5 clk = ~clk;
  assign rom_data = mem[rom_addr[5:2]];

  rom_access_arbiter #(.MAX_STARVE(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
    .stallreq(stallreq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; grant-cycle outputs checked at the falling edge.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                      input logic e_ig, input logic e_dg, input logic e_ce,
                      input logic [31:0] e_addr, input logic e_st,
                      input logic [31:0] e_id, input logic [31:0] e_dd,
                      input logic e_dacc, input logic e_err);
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
    @(negedge clk);
    chk("if_gnt",   32'(if_gnt),   32'(e_ig));
    chk("dbg_gnt",  32'(dbg_gnt),  32'(e_dg));
    chk("rom_ce",   32'(rom_ce),   32'(e_ce));
    chk("rom_addr", rom_addr,      e_addr);
    chk("stallreq", 32'(stallreq), 32'(e_st));
    if (e_ig)   if_q.push_back(e_id);
    if (e_dacc) dbg_q.push_back(e_dd);
    if (e_err)  err_q.push_back(1);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        if (if_rvalid) begin
          if (if_q.size() == 0) chk("if_unexpected_rvalid", 32'd1, 32'd0);
          else chk("if_rdata", if_rdata, if_q.pop_front());
        end
        if (dbg_rvalid) begin
          if (dbg_q.size() == 0) chk("dbg_unexpected_rvalid", 32'd1, 32'd0);
          else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
        end
        if (dbg_err) begin
          if (err_q.size() == 0) chk("dbg_unexpected_err", 32'd1, 32'd0);
          else chk("dbg_err", 32'(dbg_rvalid), 32'(1'b0) + 32'(err_q.pop_front() - 1));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | (i << 8) | i;
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h8; dbg_req = 1'b1; dbg_addr = 32'h4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset values, with both requests asserted to show the forced-inactive outputs
    chk("rst_if_rvalid",  32'(if_rvalid),  32'd0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_dbg_err",    32'(dbg_err),    32'd0);
    chk("rst_if_rdata",   if_rdata,        32'd0);
    chk("rst_dbg_rdata",  dbg_rdata,       32'd0);
    chk("rst_gnt",        32'({if_gnt, dbg_gnt}), 32'd0);
    chk("rst_rom_ce",     32'(rom_ce),     32'd0);
    chk("rst_rom_addr",   rom_addr,        32'd0);
    chk("rst_stallreq",   32'(stallreq),   32'd0);
    if_req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // IF only
    step(1, 32'h8, 0, 0,  1, 0, 1, 32'h8, 0,  M2, 0, 0, 0);
    // Reset at the end of an IF grant: response discarded, registers cleared
    step(1, 32'h4, 0, 0,  1, 0, 1, 32'h4, 0,  0, 0, 0, 0);
    if_q.delete();
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("midrst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("midrst_if_rdata",  if_rdata,       32'd0);
    chk("midrst_rom_ce",    32'(rom_ce),    32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Contention: IF wins 4 times, then debug is forced in; period 5
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) step(1, 32'h10, 1, 32'hC,  0, 1, 1, 32'hC,  1, 0, M3, 1, 0);
      else            step(1, 32'h10, 1, 32'hC,  1, 0, 1, 32'h10, 0, M4, 0, 0, 0);
    end

    // Back-to-back debug stream
    step(0, 0, 1, 32'h0,  0, 1, 1, 32'h0, 0,  0, M0, 1, 0);
    step(0, 0, 1, 32'h4,  0, 1, 1, 32'h4, 0,  0, M1, 1, 0);
    step(0, 0, 1, 32'h8,  0, 1, 1, 32'h8, 0,  0, M2, 1, 0);

    // Misaligned debug alongside IF: debug consumed, IF gets the ROM
    step(1, 32'h14, 1, 32'h6,  1, 1, 1, 32'h14, 0,  M5, 0, 0, 1);
    // Misaligned debug alone: no ROM access at all
    step(0, 0, 1, 32'h1,  0, 1, 0, 32'h0, 0,  0, 0, 0, 1);

    // Idle
    step(0, 0, 0, 0,  0, 0, 0, 32'h0, 0,  0, 0, 0, 0);
    step(0, 0, 0, 0,  0, 0, 0, 32'h0, 0,  0, 0, 0, 0);
    chk("idle_if_rdata_hold",  if_rdata,  M5);
    chk("idle_dbg_rdata_hold", dbg_rdata, M2);
    chk("idle_rvalids", 32'({if_rvalid, dbg_rvalid}), 32'd0);

    repeat (2) @(negedge clk);
    done = 1'b1;
    chk("if_q_drained",  32'(if_q.size()),  32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    chk("err_q_drained", 32'(err_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
